// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared constants and types for the 7-segment scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // All segments dark.
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // Width of one BCD digit.
    localparam int BCD_W = 4;

    // Scan controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7.sv
`default_nettype none
// ============================================================================
// Module      : seg7
// Description : BCD to 7-segment decoder, segments a..g on x[0:6],
//               active-high. Codes above 9 decode to X; callers must mask.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7
    import seg7_pkg::*;
(
    input  logic [BCD_W-1:0] s,
    output logic [0:6]       x
);

    // Segment pattern lookup for decimal digits.
    always_comb begin
        case (s)
            4'd0:    x = 7'b1111110;
            4'd1:    x = 7'b0110000;
            4'd2:    x = 7'b1101101;
            4'd3:    x = 7'b1111001;
            4'd4:    x = 7'b0110011;
            4'd5:    x = 7'b1011011;
            4'd6:    x = 7'b1011111;
            4'd7:    x = 7'b1110000;
            4'd8:    x = 7'b1111111;
            4'd9:    x = 7'b1111011;
            default: x = 7'bxxxxxxx;
        endcase
    end

endmodule : seg7
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan
// Description : Time-multiplexed scan controller for an NDIGITS 7-segment
//               display with double-buffered frame, anti-ghosting blank,
//               leading-zero suppression and invalid-code masking.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan #(
    parameter int NDIGITS = 4,
    parameter int DIV     = 1000,
    parameter int BLANK   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   din,
    input  logic [NDIGITS-1:0]     dp_in,
    input  logic                   lz_en,
    output logic [0:6]             seg,
    output logic                   dp,
    output logic [NDIGITS-1:0]     an,
    output logic                   frame_done
);
    import seg7_pkg::*;

    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = (NDIGITS > 2) ? $clog2(NDIGITS) : 1;

    localparam logic [CNT_W-1:0] c_blank_last = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0] c_cnt_last   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] c_cnt_prev   = CNT_W'(DIV - 2);
    localparam logic [IDX_W-1:0] c_idx_last   = IDX_W'(NDIGITS - 1);

    scan_state_t                     r_state;
    logic [CNT_W-1:0]                r_cnt;
    logic [IDX_W-1:0]                r_idx;

    logic [NDIGITS-1:0][BCD_W-1:0]   r_pend;
    logic [NDIGITS-1:0]              r_pend_dp;
    logic                            r_pend_valid;
    logic [NDIGITS-1:0][BCD_W-1:0]   r_act;
    logic [NDIGITS-1:0]              r_act_dp;

    logic                            w_boundary;
    logic                            w_pre_boundary;
    logic [BCD_W-1:0]                w_code;
    logic [0:6]                      w_seg_raw;
    logic                            w_invalid;
    logic                            w_blank_lz;
    logic [NDIGITS:0]                w_zero_from;

    // Last cycle of the last digit's slot; buffer swap happens on its edge.
    assign w_boundary     = (r_state == SHOW) && (r_idx == c_idx_last) && (r_cnt == c_cnt_last);
    // One cycle earlier, so the registered frame_done lands on the boundary cycle.
    assign w_pre_boundary = (r_state == SHOW) && en && (r_idx == c_idx_last) && (r_cnt == c_cnt_prev);

    assign w_code    = r_act[r_idx];
    assign w_invalid = (w_code > BCD_W'(9));

    // w_zero_from[i] is set when digits i..NDIGITS-1 are all zero.
    assign w_zero_from[NDIGITS] = 1'b1;
    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_lz
        assign w_zero_from[gi] = (r_act[gi] == '0) && w_zero_from[gi+1];
    end

    // Digit 0 is never suppressed so a zero value still shows "0".
    assign w_blank_lz = lz_en && (r_idx != '0) && w_zero_from[r_idx];

    seg7 u_seg7 (
        .s (w_code),
        .x (w_seg_raw)
    );

    // Scan sequencing: blank then show each digit slot, wrapping the digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else if (!en) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= seg7_pkg::BLANK;
                    r_cnt   <= '0;
                    r_idx   <= '0;
                end
                seg7_pkg::BLANK: begin
                    if (r_cnt == c_blank_last) begin
                        r_state <= SHOW;
                    end
                    r_cnt <= r_cnt + 1'b1;
                end
                SHOW: begin
                    if (r_cnt == c_cnt_last) begin
                        r_state <= seg7_pkg::BLANK;
                        r_cnt   <= '0;
                        r_idx   <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    // Double buffer: pending takes every load, active swaps only at the frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend       <= '0;
            r_pend_dp    <= '0;
            r_pend_valid <= 1'b0;
            r_act        <= '0;
            r_act_dp     <= '0;
        end else begin
            if (load) begin
                r_pend    <= din;
                r_pend_dp <= dp_in;
            end
            if (w_boundary) begin
                r_pend_valid <= 1'b0;
                if (load) begin
                    r_act    <= din;
                    r_act_dp <= dp_in;
                end else if (r_pend_valid) begin
                    r_act    <= r_pend;
                    r_act_dp <= r_pend_dp;
                end
            end else if (load) begin
                r_pend_valid <= 1'b1;
            end
        end
    end

    // Registered pin drivers computed from the current scan position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= SEG_OFF;
            dp         <= 1'b0;
            an         <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= w_pre_boundary;
            if (r_state == SHOW) begin
                an  <= NDIGITS'(1) << r_idx;
                seg <= (w_invalid || w_blank_lz) ? SEG_OFF : w_seg_raw;
                dp  <= r_act_dp[r_idx];
            end else begin
                an  <= '0;
                seg <= SEG_OFF;
                dp  <= 1'b0;
            end
        end
    end

endmodule : seg7_scan
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan
// Description : Directed self-checking bench for seg7_scan
//               (NDIGITS=4, DIV=8, BLANK=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan;

    localparam int ND = 4;
    localparam int DV = 8;
    localparam int BL = 2;
    localparam int FRAME = ND * DV;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          load;
    logic [15:0]   din;
    logic [3:0]    dp_in;
    logic          lz_en;
    logic [0:6]    seg;
    logic          dp;
    logic [3:0]    an;
    logic          frame_done;

    int checks   = 0;
    int failures = 0;

    seg7_scan #(
        .NDIGITS (ND),
        .DIV     (DV),
        .BLANK   (BL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .din        (din),
        .dp_in      (dp_in),
        .lz_en      (lz_en),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                           input logic e_dp, input logic e_fd);
        checks++;
        assert (an === e_an) else begin
            failures++;
            $error("FAIL %s an got=%b exp=%b", tag, an, e_an);
        end
        checks++;
        assert (seg === e_seg) else begin
            failures++;
            $error("FAIL %s seg got=%b exp=%b", tag, seg, e_seg);
        end
        checks++;
        assert (dp === e_dp) else begin
            failures++;
            $error("FAIL %s dp got=%b exp=%b", tag, dp, e_dp);
        end
        checks++;
        assert (frame_done === e_fd) else begin
            failures++;
            $error("FAIL %s frame_done got=%b exp=%b", tag, frame_done, e_fd);
        end
    endtask

    // Advance until frame_done is seen (bounded).
    task automatic wait_frame(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 3 * FRAME && !seen; i++) begin
            tick();
            seen = frame_done;
        end
        checks++;
        assert (seen === 1'b1) else begin
            failures++;
            $error("FAIL %s frame_done timeout got=%b exp=1", tag, seen);
        end
    endtask

    // Called on the frame_done cycle; checks the whole following frame and
    // returns on its frame_done cycle. Optional one-cycle load at offset load_at.
    task automatic check_frame(input string tag,
                               input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3,
                               input logic [3:0] dpv, input logic lz,
                               input int load_at, input logic [15:0] ld_din,
                               input logic [3:0] ld_dp);
        logic [6:0] s [4];
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        lz_en = lz;
        for (int k = 1; k <= FRAME; k++) begin
            tick();
            load = 1'b0;
            if (k >= 2) begin
                e_an  = 4'b0000;
                e_seg = 7'b0000000;
                e_dp  = 1'b0;
                if (k >= 4 && ((k - 4) % DV) < (DV - BL)) begin
                    e_an  = 4'b0001 << ((k - 4) / DV);
                    e_seg = s[(k - 4) / DV];
                    e_dp  = dpv[(k - 4) / DV];
                end
                chk_out(tag, e_an, e_seg, e_dp, (k == FRAME));
                checks++;
                assert (!$isunknown(seg)) else begin
                    failures++;
                    $error("FAIL %s seg_x got=%b exp=known", tag, seg);
                end
            end
            if (k == load_at) begin
                load  = 1'b1;
                din   = ld_din;
                dp_in = ld_dp;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        load  = 1'b0;
        din   = 16'h0000;
        dp_in = 4'b0000;
        lz_en = 1'b0;

        // Reset state
        #2;
        chk_out("reset", 4'b0000, 7'b0000000, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;

        // Idle with en=0 for 50 cycles
        for (int i = 0; i < 50; i++) begin
            tick();
            chk_out("idle", 4'b0000, 7'b0000000, 1'b0, 1'b0);
        end

        // Load 1234 while idle, then enable
        load = 1'b1;
        din  = 16'h1234;
        tick();
        load = 1'b0;
        en   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("en_blank", 4'b0000, 7'b0000000, 1'b0, 1'b0);
        end
        tick();
        // First frame still shows the reset-cleared active buffer
        chk_out("en_first", 4'b0001, 7'b1111110, 1'b0, 1'b0);
        wait_frame("start");

        // Basic scan of 1234
        check_frame("basic", 7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000,
                    4'b0000, 1'b0, 0, 16'h0, 4'h0);
        // Mid-frame load of 9999 must not tear the current frame
        check_frame("tear_old", 7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000,
                    4'b0000, 1'b0, 16, 16'h9999, 4'h0);
        // 9999 from the next frame; load 0070 on the frame_done cycle (bypass)
        check_frame("tear_new", 7'b1111011, 7'b1111011, 7'b1111011, 7'b1111011,
                    4'b0000, 1'b0, FRAME, 16'h0070, 4'h0);
        // Leading-zero suppression on
        check_frame("lz_on", 7'b1111110, 7'b1110000, 7'b0000000, 7'b0000000,
                    4'b0000, 1'b1, 0, 16'h0, 4'h0);
        // Leading-zero suppression off; bypass-load A005 with dp on digit 3
        check_frame("lz_off", 7'b1111110, 7'b1110000, 7'b1111110, 7'b1111110,
                    4'b0000, 1'b0, FRAME, 16'hA005, 4'b1000);
        // Invalid code on digit 3 dark but dp still shown
        check_frame("invalid", 7'b1011011, 7'b1111110, 7'b1111110, 7'b0000000,
                    4'b1000, 1'b0, 0, 16'h0, 4'h0);

        // Drop en during digit 2 SHOW
        for (int k = 1; k <= 22; k++) tick();
        chk_out("dis_pre", 4'b0100, 7'b1111110, 1'b0, 1'b0);
        en = 1'b0;
        tick();
        chk_out("dis_lag", 4'b0100, 7'b1111110, 1'b0, 1'b0);
        tick();
        chk_out("dis_off", 4'b0000, 7'b0000000, 1'b0, 1'b0);
        tick();
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("reen_blank", 4'b0000, 7'b0000000, 1'b0, 1'b0);
        end
        tick();
        chk_out("reen_d0", 4'b0001, 7'b1011011, 1'b0, 1'b0);

        // Asynchronous reset mid-SHOW
        tick();
        rst_n = 1'b0;
        #2;
        chk_out("async_rst", 4'b0000, 7'b0000000, 1'b0, 1'b0);
        en = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("post_rst", 4'b0000, 7'b0000000, 1'b0, 1'b0);
        end
        en = 1'b1;
        wait_frame("post_rst_start");
        // Active was cleared by reset and pending_valid was clear
        check_frame("rst_clr", 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110,
                    4'b0000, 1'b0, 0, 16'h0, 4'h0);
        check_frame("rst_clr_lz", 7'b1111110, 7'b0000000, 7'b0000000, 7'b0000000,
                    4'b0000, 1'b1, 0, 16'h0, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_seg7_scan
`default_nettype wire
